// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment patterns, anode codes, capture FSM states.
// Used by both the display driver and the capture side so both agree on encodings.
package seven_seg_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Active-low cathode patterns, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [3:0] ANODE_BLANK = 4'b1111;
    localparam logic [3:0] ANODE_DIG0  = 4'b1110;
    localparam logic [3:0] ANODE_DIG1  = 4'b1101;
    localparam logic [3:0] ANODE_DIG2  = 4'b1011;
    localparam logic [3:0] ANODE_DIG3  = 4'b0111;

    typedef enum logic [1:0] {
        SMP_BLANK   = 2'd0,
        SMP_SLOT    = 2'd1,
        SMP_ILLEGAL = 2'd2
    } smp_kind_e;

    typedef struct packed {
        smp_kind_e  kind;
        logic [1:0] slot;
    } smp_t;

    function automatic smp_t classify_anode(input logic [3:0] anode);
        smp_t r;
        r.kind = SMP_ILLEGAL;
        r.slot = 2'd0;
        case (anode)
            ANODE_BLANK: r.kind = SMP_BLANK;
            ANODE_DIG0:  begin r.kind = SMP_SLOT; r.slot = 2'd0; end
            ANODE_DIG1:  begin r.kind = SMP_SLOT; r.slot = 2'd1; end
            ANODE_DIG2:  begin r.kind = SMP_SLOT; r.slot = 2'd2; end
            ANODE_DIG3:  begin r.kind = SMP_SLOT; r.slot = 2'd3; end
            default:     r.kind = SMP_ILLEGAL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// Scanned-display sample inputs and captured-frame results.
// Master drives the anode/segment samples; slave (the capture block) returns frames and errors.
interface seven_seg_capture_if #(
    parameter int ERR_W = 8
);
    logic             sample_en;
    logic [3:0]       anode;
    logic [6:0]       segments;
    logic [15:0]      value;
    logic             frame_strobe;
    logic             pattern_err;
    logic             scan_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output sample_en, anode, segments,
        input  value, frame_strobe, pattern_err, scan_err, err_count
    );

    modport slave (
        input  sample_en, anode, segments,
        output value, frame_strobe, pattern_err, scan_err, err_count
    );
endinterface

// File: rtl/seven_seg_capture_seg_to_hex.sv
// Active-low segment pattern to hex nibble; unknown patterns give 0 with bad set.
// Purely combinational, no handshake.
module seg_to_hex
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nib_o,
    output logic       bad_o
);
    always_comb begin
        nib_o = 4'h0;
        bad_o = 1'b0;
        case (seg_i)
            SEG_0: nib_o = 4'h0;
            SEG_1: nib_o = 4'h1;
            SEG_2: nib_o = 4'h2;
            SEG_3: nib_o = 4'h3;
            SEG_4: nib_o = 4'h4;
            SEG_5: nib_o = 4'h5;
            SEG_6: nib_o = 4'h6;
            SEG_7: nib_o = 4'h7;
            SEG_8: nib_o = 4'h8;
            SEG_9: nib_o = 4'h9;
            SEG_A: nib_o = 4'hA;
            SEG_B: nib_o = 4'hB;
            SEG_C: nib_o = 4'hC;
            SEG_D: nib_o = 4'hD;
            SEG_E: nib_o = 4'hE;
            SEG_F: nib_o = 4'hF;
            default: bad_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/seven_seg_capture.sv
// Reassembles a multiplexed 4-digit display scan into 16-bit frames; results one cycle after the sample.
// No backpressure: every sample_en is consumed the cycle it is presented.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    seven_seg_capture_if.slave bus
);
    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [1:0]       exp_q, exp_d;
    logic [2:0][3:0]  stage_q, stage_d;
    logic             bad_q, bad_d;
    logic [15:0]      value_q, value_d;
    logic             strobe_q, strobe_d;
    logic             perr_q, perr_d;
    logic             serr_q, serr_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic [3:0] dec_nib;
    logic       dec_bad;
    smp_t       smp;

    seg_to_hex u_seg_to_hex (
        .seg_i (bus.segments),
        .nib_o (dec_nib),
        .bad_o (dec_bad)
    );

    assign smp = classify_anode(bus.anode);

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        stage_d  = stage_q;
        bad_d    = bad_q;
        value_d  = value_q;
        strobe_d = 1'b0;
        perr_d   = 1'b0;
        serr_d   = 1'b0;

        if (bus.sample_en) begin
            case (smp.kind)
                SMP_SLOT: begin
                    if (state_q == HUNT) begin
                        // Only a digit-0 sample can open a frame; others are just skipped.
                        if (smp.slot == 2'd0) begin
                            stage_d[0] = dec_nib;
                            bad_d      = dec_bad;
                            exp_d      = 2'd1;
                            state_d    = LOCK;
                        end
                    end else if (smp.slot == exp_q) begin
                        case (smp.slot)
                            2'd0: begin stage_d[0] = dec_nib; bad_d = bad_q | dec_bad; end
                            2'd1: begin stage_d[1] = dec_nib; bad_d = bad_q | dec_bad; end
                            2'd2: begin stage_d[2] = dec_nib; bad_d = bad_q | dec_bad; end
                            default: begin
                                value_d  = {dec_nib, stage_q[2], stage_q[1], stage_q[0]};
                                strobe_d = 1'b1;
                                perr_d   = bad_q | dec_bad;
                                bad_d    = 1'b0;
                            end
                        endcase
                        exp_d = exp_q + 2'd1;
                    end else if (smp.slot == 2'd0) begin
                        // Out of order but a fresh digit 0: resync without dropping to HUNT.
                        serr_d     = 1'b1;
                        stage_d[0] = dec_nib;
                        bad_d      = dec_bad;
                        exp_d      = 2'd1;
                    end else begin
                        serr_d  = 1'b1;
                        bad_d   = 1'b0;
                        exp_d   = 2'd0;
                        state_d = HUNT;
                    end
                end
                SMP_ILLEGAL: begin
                    serr_d  = 1'b1;
                    bad_d   = 1'b0;
                    exp_d   = 2'd0;
                    state_d = HUNT;
                end
                default: ;
            endcase
        end

        cnt_d = cnt_q;
        if (serr_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= HUNT;
            exp_q    <= 2'd0;
            stage_q  <= '0;
            bad_q    <= 1'b0;
            value_q  <= 16'h0000;
            strobe_q <= 1'b0;
            perr_q   <= 1'b0;
            serr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            stage_q  <= stage_d;
            bad_q    <= bad_d;
            value_q  <= value_d;
            strobe_q <= strobe_d;
            perr_q   <= perr_d;
            serr_q   <= serr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.value        = value_q;
    assign bus.frame_strobe = strobe_q;
    assign bus.pattern_err  = perr_q;
    assign bus.scan_err     = serr_q;
    assign bus.err_count    = cnt_q;
endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed vector table for seven_seg_capture plus a saturation sequence for err_count.
module tb_seven_seg_capture;

    localparam logic [3:0] S0 = 4'b1110;
    localparam logic [3:0] S1 = 4'b1101;
    localparam logic [3:0] S2 = 4'b1011;
    localparam logic [3:0] S3 = 4'b0111;
    localparam logic [3:0] BL = 4'b1111;

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        strobe;
        logic        perr;
        logic        serr;
        logic [15:0] value;
        logic [7:0]  cnt;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    seven_seg_capture_if #(.ERR_W(8)) ssif ();

    seven_seg_capture #(.ERR_W(8)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (ssif)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic rst, input logic en, input logic [3:0] an,
                                input logic [6:0] seg, input logic st, input logic pe,
                                input logic se, input logic [15:0] val, input logic [7:0] cnt);
        vec_t v;
        v.rst = rst; v.en = en; v.an = an; v.seg = seg;
        v.strobe = st; v.perr = pe; v.serr = se; v.value = val; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic [3:0] an, input logic [6:0] seg);
        @(negedge clk);
        reset          = rst;
        ssif.sample_en = en;
        ssif.anode     = an;
        ssif.segments  = seg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ssif.sample_en = 1'b0;
        ssif.anode     = BL;
        ssif.segments  = 7'h7F;

        //  rst en anode  seg     stb perr serr value     cnt
        add(1, 0, BL,    7'h7F,   0,  0,   0,   16'h0000, 0);
        add(0, 1, S0,    7'h30,   0,  0,   0,   16'h0000, 0);
        add(0, 1, S1,    7'h24,   0,  0,   0,   16'h0000, 0);
        add(0, 1, S2,    7'h79,   0,  0,   0,   16'h0000, 0);
        add(0, 1, S3,    7'h40,   1,  0,   0,   16'h0123, 0);
        add(0, 0, S0,    7'h7F,   0,  0,   0,   16'h0123, 0);
        add(1, 1, S0,    7'h00,   0,  0,   0,   16'h0000, 0);
        add(0, 1, S2,    7'h00,   0,  0,   0,   16'h0000, 0);
        add(0, 1, S3,    7'h00,   0,  0,   0,   16'h0000, 0);
        add(0, 1, S0,    7'h00,   0,  0,   0,   16'h0000, 0);
        add(0, 1, S1,    7'h00,   0,  0,   0,   16'h0000, 0);
        add(0, 1, S2,    7'h00,   0,  0,   0,   16'h0000, 0);
        add(0, 1, S3,    7'h00,   1,  0,   0,   16'h8888, 0);
        add(0, 1, S0,    7'h19,   0,  0,   0,   16'h8888, 0);
        add(0, 1, S2,    7'h19,   0,  0,   1,   16'h8888, 1);
        add(0, 1, S2,    7'h00,   0,  0,   0,   16'h8888, 1);
        add(0, 1, S0,    7'h40,   0,  0,   0,   16'h8888, 1);
        add(0, 1, 4'b1100, 7'h40, 0,  0,   1,   16'h8888, 2);
        add(0, 1, S1,    7'h79,   0,  0,   0,   16'h8888, 2);
        add(0, 1, S0,    7'h40,   0,  0,   0,   16'h8888, 2);
        add(0, 1, BL,    7'h7F,   0,  0,   0,   16'h8888, 2);
        add(0, 0, S3,    7'h00,   0,  0,   0,   16'h8888, 2);
        add(0, 1, S1,    7'h79,   0,  0,   0,   16'h8888, 2);
        add(0, 1, S2,    7'h24,   0,  0,   0,   16'h8888, 2);
        add(0, 1, S3,    7'h30,   1,  0,   0,   16'h3210, 2);
        add(0, 1, S0,    7'h40,   0,  0,   0,   16'h3210, 2);
        add(0, 1, S1,    7'h7F,   0,  0,   0,   16'h3210, 2);
        add(0, 1, S2,    7'h79,   0,  0,   0,   16'h3210, 2);
        add(0, 1, S3,    7'h24,   1,  1,   0,   16'h2100, 2);
        add(0, 1, S0,    7'h12,   0,  0,   0,   16'h2100, 2);
        add(0, 1, S1,    7'h02,   0,  0,   0,   16'h2100, 2);
        add(0, 1, S2,    7'h78,   0,  0,   0,   16'h2100, 2);
        add(0, 1, S3,    7'h10,   1,  0,   0,   16'h9765, 2);
        add(0, 1, S0,    7'h0E,   0,  0,   0,   16'h9765, 2);
        add(0, 1, S1,    7'h06,   0,  0,   0,   16'h9765, 2);
        add(0, 1, S0,    7'h08,   0,  0,   1,   16'h9765, 3);
        add(0, 1, S1,    7'h03,   0,  0,   0,   16'h9765, 3);
        add(0, 1, S2,    7'h46,   0,  0,   0,   16'h9765, 3);
        add(0, 1, S3,    7'h21,   1,  0,   0,   16'hDCBA, 3);
        add(0, 1, S2,    7'h00,   0,  0,   1,   16'hDCBA, 4);
        add(0, 1, 4'b0000, 7'h00, 0,  0,   1,   16'hDCBA, 5);
        add(0, 1, S1,    7'h00,   0,  0,   0,   16'hDCBA, 5);
        add(0, 1, S0,    7'h40,   0,  0,   0,   16'hDCBA, 5);
        add(0, 1, S1,    7'h7F,   0,  0,   0,   16'hDCBA, 5);
        add(0, 1, S3,    7'h00,   0,  0,   1,   16'hDCBA, 6);
        add(0, 1, S0,    7'h79,   0,  0,   0,   16'hDCBA, 6);
        add(0, 1, S1,    7'h79,   0,  0,   0,   16'hDCBA, 6);
        add(0, 1, S2,    7'h79,   0,  0,   0,   16'hDCBA, 6);
        add(0, 1, S3,    7'h79,   1,  0,   0,   16'h1111, 6);
        add(0, 1, S0,    7'h30,   0,  0,   0,   16'h1111, 6);
        add(0, 1, S1,    7'h30,   0,  0,   0,   16'h1111, 6);
        add(1, 1, S2,    7'h30,   0,  0,   0,   16'h0000, 0);
        add(0, 1, S2,    7'h30,   0,  0,   0,   16'h0000, 0);
        add(0, 1, S3,    7'h30,   0,  0,   0,   16'h0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].an, vecs[i].seg);
            chk($sformatf("row%0d_strobe", i), 32'(ssif.frame_strobe), 32'(vecs[i].strobe));
            chk($sformatf("row%0d_perr", i),   32'(ssif.pattern_err),  32'(vecs[i].perr));
            chk($sformatf("row%0d_serr", i),   32'(ssif.scan_err),     32'(vecs[i].serr));
            chk($sformatf("row%0d_value", i),  32'(ssif.value),        32'(vecs[i].value));
            chk($sformatf("row%0d_cnt", i),    32'(ssif.err_count),    32'(vecs[i].cnt));
        end

        // Back-to-back illegal samples in HUNT drive err_count into saturation.
        for (int i = 0; i < 300; i++) begin
            int exp_cnt;
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            drive(1'b0, 1'b1, 4'b0000, 7'h00);
            chk($sformatf("sat%0d_serr", i), 32'(ssif.scan_err), 32'd1);
            chk($sformatf("sat%0d_cnt", i), 32'(ssif.err_count), 32'(exp_cnt));
        end
        drive(1'b0, 1'b0, 4'b0000, 7'h00);
        chk("sat_idle_serr", 32'(ssif.scan_err), 32'd0);
        chk("sat_idle_cnt", 32'(ssif.err_count), 32'd255);
        chk("sat_idle_value", 32'(ssif.value), 32'h0000);

        drive(1'b1, 1'b0, BL, 7'h7F);
        chk("final_reset_cnt", 32'(ssif.err_count), 32'd0);
        chk("final_reset_serr", 32'(ssif.scan_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 Parameter ERR_W, default 8, width of the saturating error counter.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 sample_en  input  1  one-cycle strobe; anode/segments are sampled only when high.
REQ-005 anode  input  4  active-low digit select (0 = on), bit0 = rightmost digit.
REQ-006 segments  input  7  active-low cathodes, {g,f,e,d,c,b,a}, bit0 = a.
REQ-007 value  output  16  last complete frame as hex nibbles, [3:0] = digit0 ... [15:12] = digit3.
REQ-008 frame_strobe  output  1  one-cycle pulse when value updates.
REQ-009 pattern_err  output  1  valid with frame_strobe; published frame held a non-hex pattern.
REQ-010 scan_err  output  1  one-cycle pulse on an out-of-sequence or illegal anode sample.
REQ-011 err_count  output  ERR_W  saturating count of scan_err pulses.

Function
REQ-012 Sample classification on sample_en: anode 4'b1111 = blank, ignored, no state change; exactly one bit low = slot index of that bit; any other value = illegal.
REQ-013 Segment decode, active-low hex: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E; any other pattern decodes to nibble 0 and sets a per-frame bad flag.
REQ-014 FSM states HUNT and LOCK, plus a 2-bit expected-slot register exp.
REQ-015 HUNT: slot 0 captured -> store nibble0, exp=1, go LOCK; slot 1-3 -> ignored, no scan_err.
REQ-016 LOCK: slot == exp -> store nibble, exp = exp+1 mod 4.
REQ-017 LOCK, slot 3 == exp: publish all four nibbles to value atomically, frame_strobe=1 and pattern_err = frame bad flag on the next cycle; clear bad flag; exp=0, stay LOCK.
REQ-018 LOCK, slot != exp and slot == 0: scan_err pulse, discard partial frame, restart with nibble0 stored, exp=1.
REQ-019 LOCK, slot != exp and slot != 0, or illegal anode: scan_err pulse, discard partial frame, clear bad flag, go HUNT.
REQ-020 HUNT, illegal anode: scan_err pulse, stay HUNT.
REQ-021 scan_err, frame_strobe, pattern_err registered; asserted the cycle after the causing sample_en, high for exactly one cycle.
REQ-022 err_count increments with each scan_err and saturates at 2^ERR_W-1.
REQ-023 value holds its last published frame between strobes; partial frames never visible on value.
REQ-024 sample_en low: no state change regardless of anode/segments.
REQ-025 Back-to-back sample_en on consecutive cycles fully supported; one frame per 4 samples minimum.

Reset
REQ-026 reset high: state=HUNT, exp=0, staging nibbles=0, bad flag=0, value=16'h0000, frame_strobe=0, pattern_err=0, scan_err=0, err_count=0.
REQ-027 reset dominates sample_en in the same cycle; a partial frame in progress is discarded, no strobe issued.

Structure
REQ-028 Shared package/include seven_seg_pkg holds the 16 segment pattern constants, blank/anode codes and HUNT/LOCK state encodings, shared with the display driver side.
REQ-029 Combinational sub-module seg_to_hex (7-bit pattern in, 4-bit nibble plus bad flag out) is instantiated once.
REQ-030 State and exp registers built from the team's dff cell or equivalent synchronous-reset flops; all other logic combinational.

Verification
REQ-031 Reset, then samples slots 0..3 with patterns 30,24,79,40 -> one cycle after slot 3: value=16'h0123, frame_strobe=1, pattern_err=0.
REQ-032 In HUNT, samples on slots 2,3 then 0,1,2,3 with 00 each -> no scan_err, single strobe, value=16'h8888.
REQ-033 LOCK, slot 0 then slot 2 -> scan_err pulse, err_count=1, state HUNT, value unchanged.
REQ-034 Anode 4'b1100 while LOCK -> scan_err, HUNT; anode 4'b1111 -> no effect at all.
REQ-035 Full frame with digit1 pattern 7F -> strobe with pattern_err=1, value[7:4]=0; next clean frame pattern_err=0.
REQ-036 reset asserted after slots 0,1 captured -> all outputs zero, following slot 2,3 samples produce no strobe; 300 forced scan_errs with ERR_W=8 -> err_count=255.
